// File: rtl/pipe_skid_stage_pkg.sv
// Shared pipeline-stage definitions: the occupancy state encoding used by
// every registered hand-off stage.
package pipe_skid_stage_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/pipe_skid_stage.sv
// Valid/ready pipeline register with optional skid entry (SKID=1 keeps
// in_ready_o off the out_ready_i path) and a saturating output-stall counter.
module pipe_skid_stage
  import pipe_skid_stage_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  parameter bit          SKID   = 1'b1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  input  logic              cnt_clr_i,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  skid_state_e       state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              out_valid_q;
  logic              in_ready_q;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic              in_xfer, out_xfer;

  assign in_xfer  = in_valid_i && in_ready_o;
  assign out_xfer = out_valid_q && out_ready_i;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      main_q      <= '0;
      out_valid_q <= 1'b0;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      out_valid_q <= (state_d != ST_EMPTY);
      stall_q     <= stall_d;
    end
  end

  // in_ready is registered from the next state so it never sees out_ready_i
  if (SKID) begin : g_skid
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        skid_q     <= '0;
        in_ready_q <= 1'b1;
      end else begin
        skid_q     <= skid_d;
        in_ready_q <= (state_d != ST_FULL);
      end
    end
  end else begin : g_noskid
    assign skid_q     = '0;
    assign in_ready_q = 1'b1;
  end

  // Next-state / payload
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (in_xfer) begin
          main_d  = in_data_i;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (in_xfer && out_xfer) begin
          main_d = in_data_i;
        end else if (in_xfer) begin
          skid_d  = in_data_i;
          state_d = SKID ? ST_FULL : ST_BUSY;
        end else if (out_xfer) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_xfer) begin
          main_d  = skid_q;
          state_d = ST_BUSY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Flush only empties the stage; payload registers keep their content
    if (flush_i) begin
      state_d = ST_EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (cnt_clr_i) begin
      stall_d = '0;
    end else if (out_valid_q && !out_ready_i && (stall_q != '1)) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  // Outputs
  always_comb begin
    out_valid_o = out_valid_q;
    out_data_o  = main_q;
    stall_cnt_o = stall_q;
    in_ready_o  = SKID ? in_ready_q : (!out_valid_q || out_ready_i);
  end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: a SKID=1 and a SKID=0 instance driven side by
// side and compared against a bounded-FIFO reference model.
module tb_pipe_skid_stage;

  localparam int unsigned DW = 16;
  localparam int unsigned CW = 4;
  localparam int unsigned SAT = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // index 0: SKID=1 instance, index 1: SKID=0 instance
  logic          flush     [2];
  logic          in_valid  [2];
  logic          out_ready [2];
  logic          cnt_clr   [2];
  logic [DW-1:0] in_data   [2];
  logic          in_ready  [2];
  logic          out_valid [2];
  logic [DW-1:0] out_data  [2];
  logic [CW-1:0] stall_cnt [2];

  pipe_skid_stage #(.DATA_W(DW), .SKID(1'b1), .CNT_W(CW)) u_dut_skid (
    .clk(clk), .rst(rst), .flush_i(flush[0]),
    .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]), .in_data_i(in_data[0]),
    .out_valid_o(out_valid[0]), .out_ready_i(out_ready[0]), .out_data_o(out_data[0]),
    .cnt_clr_i(cnt_clr[0]), .stall_cnt_o(stall_cnt[0])
  );

  pipe_skid_stage #(.DATA_W(DW), .SKID(1'b0), .CNT_W(CW)) u_dut_reg (
    .clk(clk), .rst(rst), .flush_i(flush[1]),
    .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]), .in_data_i(in_data[1]),
    .out_valid_o(out_valid[1]), .out_ready_i(out_ready[1]), .out_data_o(out_data[1]),
    .cnt_clr_i(cnt_clr[1]), .stall_cnt_o(stall_cnt[1])
  );

  // Reference model: FIFO of capacity 2 (skid) or 1 (plain register)
  logic [DW-1:0] mbuf [2][2];
  int unsigned   mcnt [2];
  int unsigned   mstall [2];

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic exp_ready(input int i);
    if (i == 0) return (mcnt[0] < 2);
    return (mcnt[1] == 0) || out_ready[1];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mcnt[i]   = 0;
      mstall[i] = 0;
    end
  endtask

  task automatic set_idle(input int i);
    flush[i]     = 1'b0;
    in_valid[i]  = 1'b0;
    out_ready[i] = 1'b1;
    cnt_clr[i]   = 1'b0;
    in_data[i]   = DW'($urandom);
  endtask

  task automatic set_in(input int i, input logic v, input logic [DW-1:0] d, input logic ordy);
    in_valid[i]  = v;
    in_data[i]   = d;
    out_ready[i] = ordy;
  endtask

  // Called just after a negedge with inputs already applied: check, predict, advance.
  task automatic step();
    logic in_acc, out_acc;
    #1;
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("in_ready%0d", i), 64'(in_ready[i]), 64'(exp_ready(i)));
      check_eq($sformatf("out_valid%0d", i), 64'(out_valid[i]), 64'(mcnt[i] != 0));
      if (mcnt[i] != 0)
        check_eq($sformatf("out_data%0d", i), 64'(out_data[i]), 64'(mbuf[i][0]));
      check_eq($sformatf("stall_cnt%0d", i), 64'(stall_cnt[i]), 64'(mstall[i]));
    end
    for (int i = 0; i < 2; i++) begin
      in_acc  = in_valid[i] && exp_ready(i);
      out_acc = (mcnt[i] != 0) && out_ready[i];
      if (cnt_clr[i]) mstall[i] = 0;
      else if ((mcnt[i] != 0) && !out_ready[i] && (mstall[i] < SAT)) mstall[i]++;
      if (flush[i]) begin
        mcnt[i] = 0;
      end else begin
        if (out_acc) begin
          mbuf[i][0] = mbuf[i][1];
          mcnt[i]--;
        end
        if (in_acc) begin
          mbuf[i][mcnt[i]] = in_data[i];
          mcnt[i]++;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) set_idle(i);
    model_reset();
    #1;
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("rst_valid%0d", i), 64'(out_valid[i]), 64'd0);
      check_eq($sformatf("rst_ready%0d", i), 64'(in_ready[i]), 64'd1);
      check_eq($sformatf("rst_data%0d", i), 64'(out_data[i]), 64'd0);
      check_eq($sformatf("rst_stall%0d", i), 64'(stall_cnt[i]), 64'd0);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Streaming at full rate
    set_in(0, 1'b1, 16'h0011, 1'b1); step();
    check_eq("stream_first", 64'(out_data[0]), 64'h11);
    set_in(0, 1'b1, 16'h0022, 1'b1); step();
    check_eq("stream_ready", 64'(in_ready[0]), 64'd1);
    set_in(0, 1'b1, 16'h0033, 1'b1); step();
    check_eq("stream_third", 64'(out_data[0]), 64'h33);
    set_in(0, 1'b0, 16'h0000, 1'b1); step();
    step();

    // Skid fill and drain
    set_in(0, 1'b1, 16'h00A1, 1'b0); step();
    set_in(0, 1'b1, 16'h00B2, 1'b0); step();
    check_eq("skid_full_ready", 64'(in_ready[0]), 64'd0);
    set_in(0, 1'b0, 16'h0000, 1'b1);
    #1 check_eq("skid_drain_a1", 64'(out_data[0]), 64'hA1);
    step();
    check_eq("skid_drain_b2", 64'(out_data[0]), 64'hB2);
    step();

    // Flush while full, with a simultaneous input offer
    set_in(0, 1'b1, 16'h00D4, 1'b0); step();
    set_in(0, 1'b1, 16'h00E5, 1'b0); step();
    flush[0] = 1'b1;
    set_in(0, 1'b1, 16'h00C3, 1'b1); step();
    flush[0] = 1'b0;
    set_in(0, 1'b0, 16'h0000, 1'b1);
    #1;
    check_eq("flush_valid", 64'(out_valid[0]), 64'd0);
    check_eq("flush_ready", 64'(in_ready[0]), 64'd1);
    step(); step();

    // Stall counter saturation and clear priority
    set_in(0, 1'b1, 16'h0F0F, 1'b0); step();
    set_in(0, 1'b0, 16'h0000, 1'b0);
    for (int n = 0; n < 20; n++) step();
    check_eq("stall_sat", 64'(stall_cnt[0]), 64'(SAT));
    cnt_clr[0] = 1'b1; step();
    cnt_clr[0] = 1'b0;
    check_eq("stall_clr", 64'(stall_cnt[0]), 64'd0);
    step();

    // Asynchronous reset while full
    set_in(0, 1'b1, 16'h1234, 1'b0); step();
    check_eq("pre_rst_full", 64'(in_ready[0]), 64'd0);
    #1 rst = 1'b1;
    #1;
    check_eq("arst_valid", 64'(out_valid[0]), 64'd0);
    check_eq("arst_ready", 64'(in_ready[0]), 64'd1);
    check_eq("arst_stall", 64'(stall_cnt[0]), 64'd0);
    model_reset();
    #1 rst = 1'b0;
    set_in(0, 1'b1, 16'h005A, 1'b1);
    set_idle(1);
    step();
    check_eq("post_rst_accept", 64'(out_data[0]), 64'h5A);
    set_idle(0); step();

    // SKID=0: ready follows out_ready combinationally
    set_in(1, 1'b1, 16'h0077, 1'b0); step();
    set_in(1, 1'b1, 16'h0088, 1'b0);
    #1 check_eq("noskid_ready_lo", 64'(in_ready[1]), 64'd0);
    out_ready[1] = 1'b1;
    #1 check_eq("noskid_ready_hi", 64'(in_ready[1]), 64'd1);
    step();
    set_idle(1); step();

    // Random traffic against the model
    for (int n = 0; n < 10000; n++) begin
      for (int i = 0; i < 2; i++) begin
        in_valid[i]  = ($urandom_range(0, 3) != 0);
        in_data[i]   = DW'($urandom);
        out_ready[i] = ($urandom_range(0, 2) != 0);
        flush[i]     = ($urandom_range(0, 63) == 0);
        cnt_clr[i]   = ($urandom_range(0, 127) == 0);
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_skid_stage.md
PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 64, meaning payload width in bits (stage packs all pc/control/exception fields into one vector).
REQ-002 SHALL have parameter SKID, default 1, meaning 1 = two-entry skid buffer with registered in_ready_o, 0 = single register with combinational ready.
REQ-003 SHALL have parameter CNT_W, default 16, meaning stall-counter width.
REQ-004 SHALL have port clk  input  1  single clock, all logic rising-edge.
REQ-005 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-006 SHALL have port flush_i  input  1  discard all held and incoming entries.
REQ-007 SHALL have port in_valid_i  input  1  upstream entry valid.
REQ-008 SHALL have port in_ready_o  output  1  stage can accept.
REQ-009 SHALL have port in_data_i  input  DATA_W  upstream payload.
REQ-010 SHALL have port out_valid_o  output  1  downstream entry valid.
REQ-011 SHALL have port out_ready_i  input  1  downstream accepts.
REQ-012 SHALL have port out_data_o  output  DATA_W  downstream payload.
REQ-013 SHALL have port cnt_clr_i  input  1  synchronous clear of stall counter.
REQ-014 SHALL have port stall_cnt_o  output  CNT_W  saturating count of output-stall cycles.

Function
REQ-015 SHALL define transfer as valid && ready sampled at the same rising edge, on each side independently.
REQ-016 SHALL (SKID=1) implement states EMPTY, BUSY (main reg full), FULL (main + skid full).
REQ-017 SHALL, in EMPTY, on input transfer load main and go BUSY; otherwise stay EMPTY.
REQ-018 SHALL, in BUSY: in+out transfer -> main<=in_data_i, stay BUSY; in only -> skid<=in_data_i, go FULL; out only -> EMPTY; neither -> hold.
REQ-019 SHALL, in FULL, on output transfer move skid to main and go BUSY; otherwise hold.
REQ-020 SHALL drive in_ready_o = (state != FULL) directly from a flop, no combinational path from out_ready_i (SKID=1).
REQ-021 SHALL drive out_valid_o = (state != EMPTY) and out_data_o = main register, both flop outputs.
REQ-022 SHALL (SKID=0) drive in_ready_o = !out_valid_o || out_ready_i combinationally; FULL unreachable, skid register absent.
REQ-023 SHALL deliver entries in arrival order with no loss or duplication; latency in->out exactly 1 cycle when empty.
REQ-024 SHALL sustain one transfer per cycle when out_ready_i held high.
REQ-025 SHALL, when flush_i is high at an edge, enter EMPTY, overriding any simultaneous in/out transfer; the incoming entry is dropped.
REQ-026 SHALL NOT modify payload registers on flush (only state); out_data_o content after flush is don't-care until next load.
REQ-027 SHALL increment stall_cnt_o each cycle with out_valid_o=1 and out_ready_i=0, saturating at 2^CNT_W-1.
REQ-028 SHALL give cnt_clr_i priority over increment (counter becomes 0 that edge).
REQ-029 SHALL ignore in_data_i when no input transfer occurs.

Reset
REQ-030 SHALL on rst=1 asynchronously set state EMPTY: out_valid_o=0, in_ready_o=1, out_data_o=0, skid=0, stall_cnt_o=0.
REQ-031 SHALL discard any in-flight entries on reset mid-operation; first transfer after release restarts ordering.
REQ-032 SHALL accept an input transfer on the first rising edge after rst deasserts.

Structure
REQ-033 SHALL place state encoding (EMPTY/BUSY/FULL) in the shared pipeline package; payload width constants (PC_WIDTH, XLEN, OP_INFO_WIDTH) remain in the shared defines, DATA_W computed by instantiator.
REQ-034 SHALL be a single module, no sub-modules; replaces per-stage hand-written register blocks between MEM and WB and elsewhere.

Verification
REQ-035 SHALL verify streaming: out_ready_i=1, inputs 0x11,0x22,0x33 on consecutive cycles -> outputs 0x11,0x22,0x33 one cycle later, in_ready_o stays 1.
REQ-036 SHALL verify skid: BUSY with 0xA1, out_ready_i=0, input 0xB2 -> FULL, in_ready_o=0 next cycle; release -> 0xA1 then 0xB2.
REQ-037 SHALL verify flush: FULL state, flush_i=1 with in_valid_i=1 (0xC3), out_ready_i=1 -> next cycle out_valid_o=0, in_ready_o=1, 0xC3 never emitted.
REQ-038 SHALL verify counter: CNT_W=4, out stalled 20 cycles -> stall_cnt_o=15; cnt_clr_i with stall same cycle -> 0.
REQ-039 SHALL verify async reset mid-FULL: rst pulse between edges -> out_valid_o=0, in_ready_o=1 immediately, stall_cnt_o=0.
REQ-040 SHALL verify SKID=0: out_ready_i=0 with valid entry -> in_ready_o=0 same cycle; random valid/ready 10k cycles vs scoreboard, no loss.
